// File: rtl/commit_trace_serializer_if.sv
// Sample bus from the dual-issue core and trace-record stream toward the sink.
interface commit_trace_serializer_if;
  logic        in_valid;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_path0;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_data;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [15:0] out_tag;
  logic [31:0] out_data;
  logic [15:0] out_stamp;
  logic        overflow;

  modport slave (
    input  in_valid, mem_we, mem_addr, mem_data, mem_path0,
           wb0_rd, wb0_data, wb1_rd, wb1_data, out_ready,
    output in_ready, out_valid, out_kind, out_tag, out_data, out_stamp, overflow
  );

  modport master (
    output in_valid, mem_we, mem_addr, mem_data, mem_path0,
           wb0_rd, wb0_data, wb1_rd, wb1_data, out_ready,
    input  in_ready, out_valid, out_kind, out_tag, out_data, out_stamp, overflow
  );
endinterface

// File: rtl/commit_trace_serializer.sv
// Commit-trace encoder: turns each accepted core sample into 0-3 ordered
// store/register records and streams them out of a small circular FIFO.
module commit_trace_serializer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  commit_trace_serializer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 3);

  typedef struct packed {
    logic        kind;
    logic [15:0] tag;
    logic [31:0] data;
    logic [15:0] stamp;
  } rec_t;

  rec_t             mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [15:0]      stamp_r;
  logic             overflow_r;

  rec_t             store_rec_s;
  rec_t             r0_rec_s;
  rec_t             r1_rec_s;
  rec_t             cand_s [3];
  logic [2:0]       cand_v_s;
  logic [1:0]       pos_s [3];
  logic [PTR_W-1:0] wr_idx_s [3];
  logic [1:0]       n_rec_s;
  logic [1:0]       push_n_s;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             accept_s;
  logic             drop_s;
  logic             pop_s;
  rec_t             head_s;
  logic             unused_addr_lsb_s;

  assign unused_addr_lsb_s = ^bus.mem_addr[1:0];

  // Form the candidate events and arrange them in checker order for this cycle.
  always_comb begin
    store_rec_s = '{kind: 1'b1, tag: {bus.mem_addr[15:2], 2'b00},
                    data: bus.mem_data, stamp: stamp_r};
    r0_rec_s    = '{kind: 1'b0, tag: {11'd0, bus.wb0_rd},
                    data: bus.wb0_data, stamp: stamp_r};
    r1_rec_s    = '{kind: 1'b0, tag: {11'd0, bus.wb1_rd},
                    data: bus.wb1_data, stamp: stamp_r};
    cand_s[2]   = r1_rec_s;
    cand_v_s[2] = (bus.wb1_rd != 5'd0);
    if (bus.mem_path0) begin
      cand_s[0]   = store_rec_s;
      cand_v_s[0] = bus.mem_we;
      cand_s[1]   = r0_rec_s;
      cand_v_s[1] = (bus.wb0_rd != 5'd0);
    end else begin
      cand_s[0]   = r0_rec_s;
      cand_v_s[0] = (bus.wb0_rd != 5'd0);
      cand_s[1]   = store_rec_s;
      cand_v_s[1] = bus.mem_we;
    end
  end

  // Absent events are squeezed out: each present event lands at the slot
  // equal to the number of present events ahead of it.
  assign pos_s[0]    = 2'd0;
  assign pos_s[1]    = {1'b0, cand_v_s[0]};
  assign pos_s[2]    = {1'b0, cand_v_s[0]} + {1'b0, cand_v_s[1]};
  assign n_rec_s     = pos_s[2] + {1'b0, cand_v_s[2]};
  assign wr_idx_s[0] = wr_ptr_r + PTR_W'(pos_s[0]);
  assign wr_idx_s[1] = wr_ptr_r + PTR_W'(pos_s[1]);
  assign wr_idx_s[2] = wr_ptr_r + PTR_W'(pos_s[2]);

  assign in_ready_s  = (count_r <= READY_MAX);
  assign out_valid_s = (count_r != {CNT_W{1'b0}});
  assign accept_s    = bus.in_valid && in_ready_s;
  assign drop_s      = bus.in_valid && !in_ready_s && (n_rec_s != 2'd0);
  assign push_n_s    = accept_s ? n_rec_s : 2'd0;
  assign pop_s       = out_valid_s && bus.out_ready;

  // Pointers, occupancy, cycle stamp and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      stamp_r    <= 16'h0000;
      overflow_r <= 1'b0;
    end else begin
      stamp_r  <= stamp_r + 16'd1;
      count_r  <= count_r + CNT_W'(push_n_s) - CNT_W'(pop_s);
      wr_ptr_r <= wr_ptr_r + PTR_W'(push_n_s);
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Record storage; stale contents are never visible because the head is masked.
  always_ff @(posedge clk) begin
    if (rst_n && accept_s) begin
      for (int i = 0; i < 3; i++) begin
        if (cand_v_s[i]) begin
          mem_r[wr_idx_s[i]] <= cand_s[i];
        end
      end
    end
  end

  assign head_s = out_valid_s ? mem_r[rd_ptr_r] : {$bits(rec_t){1'b0}};

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_kind  = head_s.kind;
  assign bus.out_tag   = head_s.tag;
  assign bus.out_data  = head_s.data;
  assign bus.out_stamp = head_s.stamp;
  assign bus.overflow  = overflow_r;

endmodule
